// File: rtl/rv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv_mem_arbiter
//
// Shares one on-chip memory port between the instruction-fetch requester and
// the load/store (data) requester of the RV32IM core. All three interfaces use
// a req/gnt/rvalid handshake. Only one memory transaction is in flight at a
// time. When both requesters ask at once, a round-robin pointer decides, so
// neither side can starve the other.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ireq_i, iaddr_i       fetch request and byte address
//   ignt_o                fetch request accepted by memory
//   irvalid_o, irdata_o   fetch response strobe and data
//   dreq_i, dwe_i, dbe_i  data request, write enable, byte enables
//   daddr_i, dwdata_i     data byte address and write data
//   dgnt_o                data request accepted by memory
//   drvalid_o, drdata_o   data response strobe (reads and writes) and data
//   mem_req_o .. mem_wdata_o   request towards memory (registered)
//   mem_gnt_i             memory accepted the request
//   mem_rvalid_i, mem_rdata_i  memory response strobe and data
//
// MEM_LEN must be at least 18 and no larger than XLEN.
// ---------------------------------------------------------------------------
module rv_mem_arbiter #(
   parameter int XLEN    = 32,
   parameter int MEM_LEN = 18
) (
   input  logic                clk_i,
   input  logic                rst_i,
   // fetch requester
   input  logic                ireq_i,
   input  logic [XLEN-1:0]     iaddr_i,
   output logic                ignt_o,
   output logic                irvalid_o,
   output logic [XLEN-1:0]     irdata_o,
   // data requester
   input  logic                dreq_i,
   input  logic                dwe_i,
   input  logic [XLEN/8-1:0]   dbe_i,
   input  logic [XLEN-1:0]     daddr_i,
   input  logic [XLEN-1:0]     dwdata_i,
   output logic                dgnt_o,
   output logic                drvalid_o,
   output logic [XLEN-1:0]     drdata_o,
   // memory port
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [XLEN/8-1:0]   mem_be_o,
   output logic [MEM_LEN-1:0]  mem_addr_o,
   output logic [XLEN-1:0]     mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [XLEN-1:0]     mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID
   } state_t;

   state_t               r_state;
   logic                 r_ownerData;
   logic                 r_favorData;
   logic                 r_memReq;
   logic                 r_memWe;
   logic [XLEN/8-1:0]    r_memBe;
   logic [MEM_LEN-1:0]   r_memAddr;
   logic [XLEN-1:0]      r_memWdata;

   logic                 w_anyReq;
   logic                 w_pickData;
   logic                 w_nextWe;
   logic [XLEN/8-1:0]    w_nextBe;
   logic [MEM_LEN-1:0]   w_nextAddr;
   logic [XLEN-1:0]      w_nextWdata;
   logic                 w_gntHit;
   logic                 w_rvalidHit;

   // Arbitration: a lone requester always wins; on a tie the round-robin
   // pointer decides. The attributes of the winner are prepared here so the
   // IDLE and back-to-back paths of the FSM latch identical values.
   assign w_anyReq    = ireq_i | dreq_i;
   assign w_pickData  = dreq_i & (~ireq_i | r_favorData);
   assign w_nextWe    = w_pickData ? dwe_i    : 1'b0;
   assign w_nextBe    = w_pickData ? dbe_i    : '1;
   assign w_nextAddr  = w_pickData ? daddr_i[MEM_LEN-1:0] : iaddr_i[MEM_LEN-1:0];
   assign w_nextWdata = w_pickData ? dwdata_i : '0;

   // Address bits above the memory window are dropped on purpose; they are
   // gathered here only so the discard is explicit.
   generate
      if (MEM_LEN < XLEN) begin : g_dropHighAddr
         logic w_unusedHighAddr;
         assign w_unusedHighAddr = ^{iaddr_i[XLEN-1:MEM_LEN], daddr_i[XLEN-1:MEM_LEN]};
      end
   endgenerate

   // Grants and responses are steered combinationally so the owner sees them
   // in the same cycle the memory raises them. Strobes arriving in any other
   // state are simply not forwarded.
   assign w_gntHit    = (r_state == WAIT_GNT)    & mem_gnt_i;
   assign w_rvalidHit = (r_state == WAIT_RVALID) & mem_rvalid_i;

   assign ignt_o    = w_gntHit    & ~r_ownerData;
   assign dgnt_o    = w_gntHit    &  r_ownerData;
   assign irvalid_o = w_rvalidHit & ~r_ownerData;
   assign drvalid_o = w_rvalidHit &  r_ownerData;

   // Read data is forced to zero for the non-owner and outside the response
   // cycle so a requester never sees stale memory data.
   assign irdata_o  = irvalid_o ? mem_rdata_i : '0;
   assign drdata_o  = drvalid_o ? mem_rdata_i : '0;

   assign mem_req_o   = r_memReq;
   assign mem_we_o    = r_memWe;
   assign mem_be_o    = r_memBe;
   assign mem_addr_o  = r_memAddr;
   assign mem_wdata_o = r_memWdata;

   // Transaction FSM. The memory-side request is held in registers from the
   // arbitration cycle until the grant. The pointer rotates on the grant so
   // the loser of a tie wins the next one. A new request seen during the
   // response cycle is latched immediately, avoiding an idle bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_ownerData <= 1'b0;
         r_favorData <= 1'b1;
         r_memReq    <= 1'b0;
         r_memWe     <= 1'b0;
         r_memBe     <= '0;
         r_memAddr   <= '0;
         r_memWdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyReq) begin
                  r_ownerData <= w_pickData;
                  r_memReq    <= 1'b1;
                  r_memWe     <= w_nextWe;
                  r_memBe     <= w_nextBe;
                  r_memAddr   <= w_nextAddr;
                  r_memWdata  <= w_nextWdata;
                  r_state     <= WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               if (mem_gnt_i) begin
                  r_memReq    <= 1'b0;
                  r_favorData <= ~r_ownerData;
                  r_state     <= WAIT_RVALID;
               end
            end
            WAIT_RVALID: begin
               if (mem_rvalid_i) begin
                  if (w_anyReq) begin
                     r_ownerData <= w_pickData;
                     r_memReq    <= 1'b1;
                     r_memWe     <= w_nextWe;
                     r_memBe     <= w_nextBe;
                     r_memAddr   <= w_nextAddr;
                     r_memWdata  <= w_nextWdata;
                     r_state     <= WAIT_GNT;
                  end else begin
                     r_state     <= IDLE;
                  end
               end
            end
            default: begin
               r_memReq <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

endmodule
